// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory side of the core: default
// geometry (also used by instruction_reader), bytes per instruction word and
// the loader state encoding.
package riscv_pkg;

  localparam int unsigned DefPcSize      = 32;
  localparam int unsigned DefInstrSize   = 32;
  localparam int unsigned DefMaxImemRows = 4096;
  localparam int unsigned DefByteSize    = 8;

  localparam int unsigned BYTES_PER_INSTR = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone,
    StErr
  } loader_state_e;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// byte_assembler: little-endian staging of stream bytes into one word.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   clear_i        drop any partial word and restart at byte index 0
//   accept_i       a byte is consumed this cycle
//   last_i         accepted byte closes the word early (partial word)
//   byte_i         stream byte
//   complete_o     word_o holds a finished word this cycle (combinational pulse)
//   idx_o          index the next accepted byte lands at
//   word_o         staging word with the current byte merged in
module byte_assembler
  import riscv_pkg::*;
#(
  parameter int unsigned BYTE_SIZE  = DefByteSize,
  parameter int unsigned INSTR_SIZE = DefInstrSize
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clear_i,
  input  logic                              accept_i,
  input  logic                              last_i,
  input  logic [BYTE_SIZE-1:0]              byte_i,
  output logic                              complete_o,
  output logic [$clog2(BYTES_PER_INSTR)-1:0] idx_o,
  output logic [INSTR_SIZE-1:0]             word_o
);

  localparam int unsigned IdxW = $clog2(BYTES_PER_INSTR);

  logic [IdxW-1:0]       idx_q, idx_d;
  logic [INSTR_SIZE-1:0] stage_q, stage_d;

  always_comb begin
    word_o = stage_q;
    for (int unsigned k = 0; k < BYTES_PER_INSTR; k++) begin
      if (idx_q == IdxW'(k)) word_o[k*BYTE_SIZE +: BYTE_SIZE] = byte_i;
    end
    complete_o = accept_i && (last_i || idx_q == IdxW'(BYTES_PER_INSTR - 1));

    stage_d = stage_q;
    idx_d   = idx_q;
    if (clear_i) begin
      stage_d = '0;
      idx_d   = '0;
    end else if (accept_i) begin
      // Staging is zeroed on completion so a short final word has zero upper bytes.
      if (complete_o) begin
        stage_d = '0;
        idx_d   = '0;
      end else begin
        stage_d = word_o;
        idx_d   = idx_q + IdxW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
      idx_q   <= '0;
    end else begin
      stage_q <= stage_d;
      idx_q   <= idx_d;
    end
  end

  assign idx_o = idx_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit words and
// writes them to instruction memory at consecutive word addresses from 0.
// Optional: define IMEM_LOADER_CHECKSUM_EN to add checksum_o (XOR of words written).
// Ports:
//   clk_i, rst_ni       clock, async active-low reset
//   start_i             begin/restart a load (ignored while loading)
//   byte_valid_i/byte_i/last_i  byte stream; last_i marks the final byte
//   byte_ready_o        high while loading
//   imem_we_o/imem_addr_o/imem_wdata_o  one-cycle memory write
//   busy_o/done_o/error_o  state levels
//   num_instr_o         words written so far
module imem_loader
  import riscv_pkg::*;
#(
  parameter int unsigned PC_SIZE       = DefPcSize,
  parameter int unsigned INSTR_SIZE    = DefInstrSize,
  parameter int unsigned MAX_IMEM_ROWS = DefMaxImemRows,
  parameter int unsigned BYTE_SIZE     = DefByteSize
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               start_i,
  input  logic                               byte_valid_i,
  input  logic [BYTE_SIZE-1:0]               byte_i,
  input  logic                               last_i,
  output logic                               byte_ready_o,
  output logic                               imem_we_o,
  output logic [PC_SIZE-1:0]                 imem_addr_o,
  output logic [INSTR_SIZE-1:0]              imem_wdata_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               error_o,
`ifdef IMEM_LOADER_CHECKSUM_EN
  output logic [INSTR_SIZE-1:0]              checksum_o,
`endif
  output logic [$clog2(MAX_IMEM_ROWS):0]     num_instr_o
);

  localparam int unsigned RowW = $clog2(MAX_IMEM_ROWS) + 1;
  localparam int unsigned IdxW = $clog2(BYTES_PER_INSTR);

  loader_state_e         state_q;
  logic [RowW-1:0]       row_q;
  logic                  we_q;
  logic [PC_SIZE-1:0]    addr_q;
  logic [INSTR_SIZE-1:0] wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [INSTR_SIZE-1:0] cks_q;
`endif

  logic                  accept;
  logic                  overflow;
  logic                  restart;
  logic                  word_done;
  logic [IdxW-1:0]       idx;
  logic [INSTR_SIZE-1:0] word;

  assign accept   = byte_valid_i && (state_q == StLoad);
  assign overflow = (row_q == RowW'(MAX_IMEM_ROWS));
  assign restart  = start_i && (state_q != StLoad);

  byte_assembler #(
    .BYTE_SIZE  (BYTE_SIZE),
    .INSTR_SIZE (INSTR_SIZE)
  ) u_asm (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (restart),
    .accept_i   (accept && !overflow),  // overflowing byte is dropped
    .last_i     (last_i),
    .byte_i     (byte_i),
    .complete_o (word_done),
    .idx_o      (idx),
    .word_o     (word)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      row_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      cks_q   <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state_q)
        StIdle, StDone, StErr: begin
          if (start_i) begin
            state_q <= StLoad;
            row_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            cks_q   <= '0;
`endif
          end
        end
        StLoad: begin
          if (accept) begin
            if (overflow) begin
              state_q <= StErr;
            end else begin
              if (word_done) begin
                // Row advances at the completing edge; the strobe follows in the next cycle.
                we_q    <= 1'b1;
                addr_q  <= PC_SIZE'({row_q, 2'b00});
                wdata_q <= word;
                row_q   <= row_q + RowW'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                cks_q   <= cks_q ^ word;
`endif
              end
              if (last_i) begin
                state_q <= (idx == IdxW'(BYTES_PER_INSTR - 1)) ? StDone : StErr;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign byte_ready_o = (state_q == StLoad);
  assign busy_o       = (state_q == StLoad);
  assign done_o       = (state_q == StDone);
  assign error_o      = (state_q == StErr);
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign num_instr_o  = row_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign checksum_o   = cks_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (MAX_IMEM_ROWS=4 so overflow is reachable).
module tb_imem_loader;

  localparam int unsigned Max  = 4;
  localparam int unsigned NumW = $clog2(Max) + 1;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic            start_i = 1'b0;
  logic            byte_valid_i = 1'b0;
  logic [7:0]      byte_i = '0;
  logic            last_i = 1'b0;
  logic            byte_ready_o;
  logic            imem_we_o;
  logic [31:0]     imem_addr_o;
  logic [31:0]     imem_wdata_o;
  logic            busy_o;
  logic            done_o;
  logic            error_o;
  logic [NumW-1:0] num_instr_o;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]     checksum_o;
`endif

  always #5 clk = ~clk;

  imem_loader #(
    .PC_SIZE       (32),
    .INSTR_SIZE    (32),
    .MAX_IMEM_ROWS (Max),
    .BYTE_SIZE     (8)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .byte_valid_i (byte_valid_i),
    .byte_i       (byte_i),
    .last_i       (last_i),
    .byte_ready_o (byte_ready_o),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .checksum_o   (checksum_o),
`endif
    .num_instr_o  (num_instr_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Observed writes {addr, data}, one entry per strobe cycle.
  logic [63:0] wq[$];
  always @(negedge clk) if (imem_we_o === 1'b1) wq.push_back({imem_addr_o, imem_wdata_o});

  // Reference model results.
  logic [63:0] exp_w[$];
  bit          m_done, m_err, m_busy;
  int          m_num;
  logic [31:0] m_cks;

  // Expected outcome of a stream: words are consecutive groups of four bytes,
  // capacity is Max words, an extra byte is an overflow.
  task automatic model(input logic [7:0] bs[$], input bit last);
    int n, cap, used, nw;
    logic [31:0] w;
    n    = bs.size();
    cap  = 4 * Max;
    used = (n > cap) ? cap : n;
    nw   = (last || n > cap) ? (used + 3) / 4 : used / 4;
    exp_w.delete();
    m_cks = '0;
    for (int i = 0; i < nw; i++) begin
      w = '0;
      for (int k = 0; k < 4; k++) if (4 * i + k < used) w[8*k +: 8] = bs[4*i+k];
      exp_w.push_back({32'(4 * i), w});
      m_cks ^= w;
    end
    m_err  = (n > cap) || (last && (n % 4) != 0);
    m_done = last && !m_err;
    m_busy = !m_err && !last;
    m_num  = nw;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; start_i = 1'b0; byte_valid_i = 1'b0; last_i = 1'b0; byte_i = '0;
    tick(2);
    rst_ni = 1'b1;
    tick(1);
    wq.delete();
  endtask

  task automatic start_load();
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  // Idle gap cycles carry random byte/last with valid low; they must be ignored.
  task automatic send_byte(input logic [7:0] b, input bit last, input int gap);
    int n;
    byte_valid_i = 1'b0;
    repeat (gap) begin
      byte_i = 8'($urandom);
      last_i = 1'($urandom);
      tick(1);
    end
    byte_valid_i = 1'b1; byte_i = b; last_i = last;
    n = 0;
    while (byte_ready_o !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    if (n == 20) begin
      vectors++; miscompares++;
      $display("FAIL ready_timeout: byte_ready_o=%b after 20 cycles, required 1", byte_ready_o);
    end
    tick(1);
    byte_valid_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic test_stream(input string name, input logic [7:0] bs[$], input bit last,
                             input int gapmax);
    do_reset();
    start_load();
    for (int i = 0; i < bs.size(); i++)
      send_byte(bs[i], last && (i == bs.size() - 1), $urandom_range(gapmax, 0));
    tick(3);
    model(bs, last);
    vectors++;
    if (wq.size() != exp_w.size()) begin
      miscompares++;
      $display("FAIL %s write_count: got %0d, required %0d", name, wq.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < wq.size(); i++) begin
      vectors++;
      if (wq[i] !== exp_w[i]) begin
        miscompares++;
        $display("FAIL %s write[%0d]: got addr/data %h, required %h", name, i, wq[i], exp_w[i]);
      end
    end
    vectors++;
    if ({done_o, error_o, busy_o, byte_ready_o} !== {m_done, m_err, m_busy, m_busy}) begin
      miscompares++;
      $display("FAIL %s status: got done/err/busy/ready %b%b%b%b, required %b%b%b%b", name,
               done_o, error_o, busy_o, byte_ready_o, m_done, m_err, m_busy, m_busy);
    end
    vectors++;
    if (num_instr_o !== NumW'(m_num)) begin
      miscompares++;
      $display("FAIL %s num_instr: got %0d, required %0d", name, num_instr_o, m_num);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    vectors++;
    if (checksum_o !== m_cks) begin
      miscompares++;
      $display("FAIL %s checksum: got %h, required %h", name, checksum_o, m_cks);
    end
`endif
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #1;
    vectors++;
    if ({byte_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, busy_o, done_o, error_o,
         num_instr_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got we=%b addr=%h data=%h busy=%b done=%b err=%b num=%0d, required all 0",
               imem_we_o, imem_addr_o, imem_wdata_o, busy_o, done_o, error_o, num_instr_o);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    vectors++;
    if (checksum_o !== '0) begin
      miscompares++;
      $display("FAIL reset_checksum: got %h, required 0", checksum_o);
    end
`endif
  endtask

  task automatic test_basic();
    logic [7:0] bs[$];
    bs = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h20, 8'h00};
    test_stream("basic", bs, 1'b1, 0);
    vectors++;
    if (wq.size() != 2 || wq[0] !== 64'h0000_0000_0000_0013 || wq[1] !== 64'h0000_0004_0020_00B3) begin
      miscompares++;
      $display("FAIL basic_writes: got %0d writes, required 0x0:00000013 and 0x4:002000B3", wq.size());
    end
    vectors++;
    if (done_o !== 1'b1 || error_o !== 1'b0 || num_instr_o !== NumW'(2)) begin
      miscompares++;
      $display("FAIL basic_status: got done=%b err=%b num=%0d, required 1 0 2", done_o, error_o,
               num_instr_o);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    vectors++;
    if (checksum_o !== 32'h0020_00A0) begin
      miscompares++;
      $display("FAIL basic_checksum: got %h, required 002000a0", checksum_o);
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [7:0] bs[$];
    bs = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h20, 8'h00};
    for (int r = 0; r < 3; r++) test_stream("backpressure", bs, 1'b1, 4);
  endtask

  task automatic test_partial();
    logic [7:0] bs[$];
    bs = '{8'hAA, 8'hBB};
    test_stream("partial", bs, 1'b1, 1);
    vectors++;
    if (wq.size() != 1 || wq[0] !== 64'h0000_0000_0000_BBAA || error_o !== 1'b1
        || num_instr_o !== NumW'(1)) begin
      miscompares++;
      $display("FAIL partial_result: got %0d writes err=%b num=%0d, required 1 write 0x0:0000bbaa err=1 num=1",
               wq.size(), error_o, num_instr_o);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] bs[$];
    bs.delete();
    for (int i = 0; i < 16; i++) bs.push_back(8'($urandom));
    test_stream("fill_exact", bs, 1'b1, 1);
    vectors++;
    if (wq.size() != 4 || done_o !== 1'b1 || num_instr_o !== NumW'(4)) begin
      miscompares++;
      $display("FAIL fill_exact_result: got %0d writes done=%b num=%0d, required 4 1 4", wq.size(),
               done_o, num_instr_o);
    end
    bs.push_back(8'h5A);
    test_stream("overflow", bs, 1'b0, 1);
    vectors++;
    if (wq.size() != 4 || error_o !== 1'b1 || num_instr_o !== NumW'(4)) begin
      miscompares++;
      $display("FAIL overflow_result: got %0d writes err=%b num=%0d, required 4 1 4", wq.size(),
               error_o, num_instr_o);
    end
  endtask

  task automatic test_reset_midload();
    // Reset after two bytes of the first word.
    do_reset();
    start_load();
    send_byte(8'h13, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    rst_ni = 1'b0;
    #1;
    vectors++;
    if ({byte_ready_o, imem_we_o, busy_o, done_o, error_o, num_instr_o} !== '0) begin
      miscompares++;
      $display("FAIL midload_reset: got ready=%b we=%b busy=%b num=%0d, required all 0",
               byte_ready_o, imem_we_o, busy_o, num_instr_o);
    end
    // Reset landing in the strobe cycle must suppress that write.
    do_reset();
    start_load();
    for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'h13 : 8'h00, 1'b0, 0);
    rst_ni = 1'b0;
    #1;
    vectors++;
    if (imem_we_o !== 1'b0) begin
      miscompares++;
      $display("FAIL strobe_reset: got we=%b, required 0", imem_we_o);
    end
    tick(2);
    vectors++;
    if (wq.size() != 0) begin
      miscompares++;
      $display("FAIL strobe_suppressed: got %0d writes, required 0", wq.size());
    end
    rst_ni = 1'b1;
    tick(1);
    start_load();
    for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'h13 : 8'h00, i == 3, 0);
    tick(3);
    vectors++;
    if (wq.size() != 1 || wq[0] !== 64'h0000_0000_0000_0013 || done_o !== 1'b1
        || num_instr_o !== NumW'(1)) begin
      miscompares++;
      $display("FAIL reload_after_reset: got %0d writes done=%b num=%0d, required 0x0:00000013 1 1",
               wq.size(), done_o, num_instr_o);
    end
  endtask

  task automatic test_ignored();
    // From DONE: valid/last are ignored, then restart clears, start mid-load ignored.
    logic [7:0] bs[$];
    bs = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h20, 8'h00};
    test_stream("pre_ignored", bs, 1'b1, 0);
    wq.delete();
    byte_valid_i = 1'b1; last_i = 1'b1; byte_i = 8'hEE;
    tick(4);
    byte_valid_i = 1'b0; last_i = 1'b0;
    tick(2);
    vectors++;
    if (wq.size() != 0 || done_o !== 1'b1 || num_instr_o !== NumW'(2)) begin
      miscompares++;
      $display("FAIL valid_outside_load: got %0d writes done=%b num=%0d, required 0 1 2",
               wq.size(), done_o, num_instr_o);
    end
    start_load();
    vectors++;
    if (busy_o !== 1'b1 || done_o !== 1'b0 || error_o !== 1'b0 || num_instr_o !== '0) begin
      miscompares++;
      $display("FAIL restart_clear: got busy=%b done=%b err=%b num=%0d, required 1 0 0 0",
               busy_o, done_o, error_o, num_instr_o);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    vectors++;
    if (checksum_o !== '0) begin
      miscompares++;
      $display("FAIL restart_checksum: got %h, required 0", checksum_o);
    end
`endif
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    start_load();
    send_byte(8'h33, 1'b0, 0);
    send_byte(8'h44, 1'b1, 0);
    tick(3);
    vectors++;
    if (wq.size() != 1 || wq[0] !== 64'h0000_0000_4433_2211 || done_o !== 1'b1) begin
      miscompares++;
      $display("FAIL start_in_load: got %0d writes first=%h done=%b, required 1 write 0x0:44332211 done=1",
               wq.size(), (wq.size() > 0) ? wq[0] : 64'h0, done_o);
    end
  endtask

  task automatic test_random();
    logic [7:0] bs[$];
    int n;
    bit last;
    for (int it = 0; it < 16; it++) begin
      n = $urandom_range(17, 1);
      bs.delete();
      for (int i = 0; i < n; i++) bs.push_back(8'($urandom));
      last = ($urandom_range(3, 0) != 0);
      test_stream("random", bs, last, 3);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_partial();
    test_overflow();
    test_reset_midload();
    test_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
